// File: rtl/planificador_sensores_pkg.sv
// Shared types and constants for the sensor scan controller.
package monitoreo_pkg;

  localparam int TEMP_W = 11;

  typedef logic signed [TEMP_W-1:0] temp_t;

  localparam temp_t TEMP_MIN_DEF = 11'sd10;
  localparam temp_t TEMP_MAX_DEF = 11'sd40;

  typedef enum logic [1:0] {
    REPOSO   = 2'd0,
    SOLICITA = 2'd1,
    ESPERA   = 2'd2,
    EVALUA   = 2'd3
  } estado_planif_t;

  function automatic logic en_rango(input temp_t t, input temp_t lo, input temp_t hi);
    return (t >= lo) && (t <= hi);
  endfunction

endpackage

// File: rtl/planificador_sensores_if.sv
// Sensor front-end / actuator bus of the scan controller; master = controller side.
interface planificador_sensores_if
  import monitoreo_pkg::*;
#(
  parameter int N_CANALES = 4
);
  localparam int CW = $clog2(N_CANALES);

  logic                 habilitar;
  logic                 sol_valid;
  logic [CW-1:0]        sol_canal;
  logic                 dato_valid;
  temp_t                dato_temp;
  logic [N_CANALES-1:0] alerta_canal;
  logic [N_CANALES-1:0] falla_sensor;
  logic                 calefactor;
  logic                 ventilador;
  logic                 conflicto;
  logic [1:0]           estado_actual;

  modport master (
    input  habilitar, dato_valid, dato_temp,
    output sol_valid, sol_canal, alerta_canal, falla_sensor,
           calefactor, ventilador, conflicto, estado_actual
  );

  modport slave (
    output habilitar, dato_valid, dato_temp,
    input  sol_valid, sol_canal, alerta_canal, falla_sensor,
           calefactor, ventilador, conflicto, estado_actual
  );

endinterface

// File: rtl/planificador_sensores_contador_canal.sv
// Per-channel persistence counter, direction, alarm and sensor-fault state.
module contador_canal
  import monitoreo_pkg::*;
#(
  parameter int    PERSIST  = 5,
  parameter temp_t TEMP_MIN = TEMP_MIN_DEF,
  parameter temp_t TEMP_MAX = TEMP_MAX_DEF
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  evaluar_i,
  input  logic  sin_respuesta_i,
  input  temp_t temp_i,
  output logic  alerta_o,
  output logic  falla_o,
  output logic  alerta_d_o,
  output logic  dir_d_o
);

  localparam int CNT_W = $clog2(PERSIST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PERSIST);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             alerta_q, alerta_d;
  logic             falla_q, falla_d;

  // NOTE: every next-state variable gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    alerta_d = alerta_q;
    falla_d  = falla_q;
    if (evaluar_i) begin
      if (sin_respuesta_i) begin
        falla_d = 1'b1;
      end else if (en_rango(temp_i, TEMP_MIN, TEMP_MAX)) begin
        cnt_d    = '0;
        alerta_d = 1'b0;
        falla_d  = 1'b0;
      end else begin
        // A cold/hot swing keeps counting; only an in-range sample restarts persistence.
        cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        dir_d    = (temp_i > TEMP_MAX);
        alerta_d = (cnt_d == CNT_MAX);
        falla_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      dir_q    <= 1'b0;
      alerta_q <= 1'b0;
      falla_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      alerta_q <= alerta_d;
      falla_q  <= falla_d;
    end
  end

  assign alerta_o   = alerta_q;
  assign falla_o    = falla_q;
  assign alerta_d_o = alerta_d;
  assign dir_d_o    = dir_d;

endmodule

// File: rtl/planificador_sensores.sv
// Round-robin sensor scan FSM with persistent alarms driving heater and fan.
// Optional ESPERA watchdog and sensor-fault flags: `define PLANIF_TIMEOUT_EN.
module planificador_sensores
  import monitoreo_pkg::*;
#(
  parameter int    N_CANALES = 4,
  parameter int    PERSIST   = 5,
  parameter temp_t TEMP_MIN  = TEMP_MIN_DEF,
  parameter temp_t TEMP_MAX  = TEMP_MAX_DEF,
  parameter int    TIMEOUT   = 15
) (
  input logic                      clk,
  input logic                      rst,
  planificador_sensores_if.master  bus
);

  localparam int CW = $clog2(N_CANALES);
  localparam logic [CW-1:0] ULTIMO = CW'(N_CANALES - 1);

  estado_planif_t       estado_q;
  logic [CW-1:0]        canal_q;
  logic                 sol_valid_q;
  temp_t                temp_q;
  logic                 sin_respuesta;
  logic [N_CANALES-1:0] evaluar, alerta_q, falla_q, alerta_d, dir_d;
  logic                 calefactor_q, ventilador_q, conflicto_q;
  logic                 frio, caliente;

`ifdef PLANIF_TIMEOUT_EN
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_FIN = WAIT_W'(TIMEOUT - 1);
  logic [WAIT_W-1:0] espera_q;
  logic              timeout_q;
  assign sin_respuesta = timeout_q;
`else
  assign sin_respuesta = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q    <= REPOSO;
      canal_q     <= '0;
      sol_valid_q <= 1'b0;
      temp_q      <= '0;
`ifdef PLANIF_TIMEOUT_EN
      espera_q    <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      sol_valid_q <= 1'b0;
      unique case (estado_q)
        REPOSO: begin
          if (bus.habilitar) begin
            estado_q    <= SOLICITA;
            sol_valid_q <= 1'b1;
          end
        end
        SOLICITA: begin
          estado_q <= ESPERA;
`ifdef PLANIF_TIMEOUT_EN
          espera_q  <= '0;
          timeout_q <= 1'b0;
`endif
        end
        ESPERA: begin
          if (bus.dato_valid) begin
            temp_q   <= bus.dato_temp;
            estado_q <= EVALUA;
          end
`ifdef PLANIF_TIMEOUT_EN
          else if (espera_q == WAIT_FIN) begin
            timeout_q <= 1'b1;
            estado_q  <= EVALUA;
          end else begin
            espera_q <= espera_q + 1'b1;
          end
`endif
        end
        EVALUA: begin
          canal_q <= (canal_q == ULTIMO) ? '0 : canal_q + 1'b1;
          if (bus.habilitar) begin
            estado_q    <= SOLICITA;
            sol_valid_q <= 1'b1;
          end else begin
            estado_q <= REPOSO;
          end
        end
        default: estado_q <= REPOSO;
      endcase
    end
  end

  for (genvar c = 0; c < N_CANALES; c++) begin : g_canal
    assign evaluar[c] = (estado_q == EVALUA) && (canal_q == CW'(c));

    contador_canal #(
      .PERSIST  (PERSIST),
      .TEMP_MIN (TEMP_MIN),
      .TEMP_MAX (TEMP_MAX)
    ) u_contador (
      .clk             (clk),
      .rst             (rst),
      .evaluar_i       (evaluar[c]),
      .sin_respuesta_i (sin_respuesta),
      .temp_i          (temp_q),
      .alerta_o        (alerta_q[c]),
      .falla_o         (falla_q[c]),
      .alerta_d_o      (alerta_d[c]),
      .dir_d_o         (dir_d[c])
    );
  end

  // Actuators follow next-state alarms so they land on the same edge as alerta_canal.
  always_comb begin
    frio     = |(alerta_d & ~dir_d);
    caliente = |(alerta_d & dir_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      calefactor_q <= 1'b0;
      ventilador_q <= 1'b0;
      conflicto_q  <= 1'b0;
    end else begin
      calefactor_q <= frio & ~caliente;
      ventilador_q <= caliente & ~frio;
      conflicto_q  <= frio & caliente;
    end
  end

  assign bus.sol_valid     = sol_valid_q;
  assign bus.sol_canal     = canal_q;
  assign bus.alerta_canal  = alerta_q;
  assign bus.falla_sensor  = falla_q;
  assign bus.calefactor    = calefactor_q;
  assign bus.ventilador    = ventilador_q;
  assign bus.conflicto     = conflicto_q;
  assign bus.estado_actual = estado_q;

endmodule

// File: tb/tb_planificador_sensores.sv
// Randomized self-checking bench for planificador_sensores against a per-channel behavioural model.
module tb_planificador_sensores;
  import monitoreo_pkg::*;

  localparam int N       = 4;
  localparam int PERSIST = 5;
  localparam int TMIN    = 10;
  localparam int TMAX    = 40;
  localparam int TIMEOUT = 15;
`ifdef PLANIF_TIMEOUT_EN
  localparam int MAX_DELAY = TIMEOUT;
`else
  localparam int MAX_DELAY = 20;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  planificador_sensores_if #(.N_CANALES(N)) bus ();

  planificador_sensores #(
    .N_CANALES (N),
    .PERSIST   (PERSIST),
    .TEMP_MIN  (11'sd10),
    .TEMP_MAX  (11'sd40),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  int m_cnt   [N];
  bit m_dir   [N];
  bit m_alert [N];
  bit m_fault [N];
  int m_ptr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < N; c++) begin
      m_cnt[c] = 0; m_dir[c] = 0; m_alert[c] = 0; m_fault[c] = 0;
    end
    m_ptr = 0;
  endfunction

  function automatic void model_eval(input int c, input int t, input bit got);
    if (!got) begin
`ifdef PLANIF_TIMEOUT_EN
      m_fault[c] = 1;
`endif
    end else if (t >= TMIN && t <= TMAX) begin
      m_cnt[c] = 0; m_alert[c] = 0; m_fault[c] = 0;
    end else begin
      m_cnt[c]   = (m_cnt[c] + 1 > PERSIST) ? PERSIST : m_cnt[c] + 1;
      m_dir[c]   = (t > TMAX);
      m_alert[c] = (m_cnt[c] >= PERSIST);
      m_fault[c] = 0;
    end
  endfunction

  task automatic check_outputs(input string tag);
    logic [N-1:0] ea, ef;
    bit frio, cal;
    frio = 0; cal = 0;
    for (int c = 0; c < N; c++) begin
      ea[c] = m_alert[c];
      ef[c] = m_fault[c];
      if (m_alert[c] && !m_dir[c]) frio = 1;
      if (m_alert[c] && m_dir[c])  cal  = 1;
    end
    check({tag, "_alerta"}, bus.alerta_canal, ea);
    check({tag, "_falla"},  bus.falla_sensor, ef);
    check({tag, "_calef"},  bus.calefactor, frio && !cal);
    check({tag, "_vent"},   bus.ventilador, cal && !frio);
    check({tag, "_confl"},  bus.conflicto, frio && cal);
  endtask

  task automatic wait_sol(output bit found);
    for (int i = 0; i < 40 && bus.sol_valid !== 1'b1; i++) @(negedge clk);
    found = (bus.sol_valid === 1'b1);
  endtask

  // One complete channel visit: request, reply after `delay` ESPERA cycles (or none), evaluation.
  task automatic scan(input int t, input int delay, input bit reply, input bit seguir);
    bit found;
    bus.habilitar = 1'b1;
    wait_sol(found);
    check("sol_pulse", found, 1);
    if (!found) return;
    check("sol_canal", bus.sol_canal, m_ptr);
    check("st_solicita", bus.estado_actual, 1);
    bus.dato_valid = 1'($urandom_range(0, 1));
    bus.dato_temp  = 11'sd100;
    if (reply) begin
      for (int j = 1; j <= delay; j++) begin
        @(negedge clk);
        check("st_espera", bus.estado_actual, 2);
        if (j == delay) begin
          bus.dato_valid = 1'b1;
          bus.dato_temp  = 11'(t);
          bus.habilitar  = seguir;
        end else begin
          bus.dato_valid = 1'b0;
          bus.dato_temp  = 11'($urandom_range(0, 2047));
        end
      end
    end else begin
      for (int j = 1; j <= TIMEOUT; j++) begin
        @(negedge clk);
        bus.dato_valid = 1'b0;
        bus.habilitar  = seguir;
      end
      check("st_espera_fin", bus.estado_actual, 2);
    end
    @(negedge clk);
    check("st_evalua", bus.estado_actual, 3);
    bus.dato_valid = 1'($urandom_range(0, 1));
    bus.dato_temp  = -11'sd500;
    @(negedge clk);
    bus.dato_valid = 1'b0;
    model_eval(m_ptr, t, reply);
    m_ptr = (m_ptr + 1) % N;
    check("st_salida", bus.estado_actual, seguir ? 1 : 0);
    check("sol_salida", bus.sol_valid, seguir);
    check_outputs("eval");
  endtask

  task automatic round_all(input int t_def, input int c_a, input int t_a, input int c_b, input int t_b);
    for (int k = 0; k < N; k++) begin
      int t;
      t = (m_ptr == c_a) ? t_a : ((m_ptr == c_b) ? t_b : t_def);
      scan(t, $urandom_range(1, 4), 1'b1, 1'b1);
    end
  endtask

  int pool [10] = '{-1024, -5, 9, 10, 11, 25, 39, 40, 41, 1023};
  int bseq [15] = '{9, 9, 9, 9, 10, 41, 41, 41, 41, 40, 9, 41, 9, 41, 9};

  initial begin
    bit found;
    rst            = 1'b1;
    bus.habilitar  = 1'b0;
    bus.dato_valid = 1'b0;
    bus.dato_temp  = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_estado", bus.estado_actual, 0);
    check("rst_sol", bus.sol_valid, 0);
    check("rst_canal", bus.sol_canal, 0);
    check_outputs("rst");
    rst = 1'b0;
    @(negedge clk);
    check("reposo_sin_hab", bus.estado_actual, 0);

    // Pointer order 0,1,2,3,0 with replies on the first ESPERA cycle.
    for (int i = 0; i < 5; i++) scan(25, 1, 1'b1, 1'b1);

    // Channel 1 hot for five visits, then back in range.
    for (int r = 0; r < 5; r++) round_all(25, 1, 50, -1, 0);
    check("hot_alerta", bus.alerta_canal, 4'b0010);
    check("hot_vent", bus.ventilador, 1);
    round_all(25, -1, 0, -1, 0);
    check("hot_clr_alerta", bus.alerta_canal, 4'b0000);
    check("hot_clr_vent", bus.ventilador, 0);

    // Channel 0 cold and channel 2 hot together.
    for (int r = 0; r < 5; r++) round_all(25, 0, 5, 2, 45);
    check("confl", bus.conflicto, 1);
    check("confl_calef", bus.calefactor, 0);
    check("confl_vent", bus.ventilador, 0);
    round_all(25, -1, 0, -1, 0);

    // Inclusive limits and a cold/hot swing without an in-range reset.
    for (int r = 0; r < 15; r++) round_all(25, 0, bseq[r], -1, 0);
    check("limite_alerta0", bus.alerta_canal[0], 1);
    check("limite_calef", bus.calefactor, 1);

    // Randomized scans with random latency, enable drops and (when present) timeouts.
    for (int i = 0; i < 80; i++) begin
      int  t;
      bit  reply, seguir;
      t = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 2047)) - 1024
                                      : pool[$urandom_range(0, 9)];
`ifdef PLANIF_TIMEOUT_EN
      reply = ($urandom_range(0, 5) != 0);
`else
      reply = 1'b1;
`endif
      seguir = ($urandom_range(0, 4) != 0);
      scan(t, $urandom_range(1, MAX_DELAY), reply, seguir);
      if (!seguir) begin
        repeat ($urandom_range(1, 4)) begin
          @(negedge clk);
          check("reposo_idle", bus.estado_actual, 0);
        end
      end
    end

    // Silent sensor on channel 3.
    while (m_ptr != 3) scan(25, 1, 1'b1, 1'b1);
`ifdef PLANIF_TIMEOUT_EN
    scan(0, 0, 1'b0, 1'b1);
    check("timeout_falla3", bus.falla_sensor[3], 1);
    scan(25, 1, 1'b1, 1'b1);
`else
    bus.habilitar = 1'b1;
    wait_sol(found);
    check("sin_to_sol", found, 1);
    repeat (40) @(negedge clk);
    check("sin_to_espera", bus.estado_actual, 2);
    check("sin_to_falla", bus.falla_sensor, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
`endif

    // Reset in ESPERA with a reply in the same cycle.
    bus.habilitar = 1'b1;
    wait_sol(found);
    check("rst_esp_sol", found, 1);
    @(negedge clk);
    check("rst_esp_espera", bus.estado_actual, 2);
    rst            = 1'b1;
    bus.dato_valid = 1'b1;
    bus.dato_temp  = 11'sd50;
    @(negedge clk);
    rst            = 1'b0;
    bus.dato_valid = 1'b0;
    model_reset();
    check("rst_esp_estado", bus.estado_actual, 0);
    check("rst_esp_canal", bus.sol_canal, 0);
    check_outputs("rst_esp");
    for (int r = 0; r < 4; r++) round_all(50, -1, 0, -1, 0);
    check("cnt_cero_4", bus.alerta_canal, 4'b0000);
    round_all(50, -1, 0, -1, 0);
    check("cnt_cero_5", bus.alerta_canal, 4'b1111);
    check("cnt_cero_vent", bus.ventilador, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/planificador_sensores.md
# planificador_sensores

Round-robin scan controller that shares one temperature acquisition interface between N sensor channels. For each channel it requests a sample, waits for the reply with an optional timeout, and classifies the reading against fixed limits. It keeps a per-channel persistence count and drives the shared heater and fan from the combined channel alarms. It sits between the sensor front-end and the actuator outputs of the monitoring subsystem.

## Interface
- N_CANALES, 4: number of scanned channels (≥2)
- PERSIST, 5: consecutive out-of-range samples required to raise a channel alarm
- TEMP_MIN, 11'sd10: lower limit; a sample below it is "cold"
- TEMP_MAX, 11'sd40: upper limit; a sample above it is "hot"
- TIMEOUT, 15: cycles waited for a reply before declaring a sensor fault
- clk  in  1  system clock; everything is on the rising edge
- rst  in  1  synchronous reset, active-high
- habilitar  in  1  scan enable
- sol_valid  out  1  one-cycle sample request
- sol_canal  out  $clog2(N_CANALES)  channel being requested; stable from SOLICITA through EVALUA
- dato_valid  in  1  reply strobe
- dato_temp  in  signed 11  reply temperature, valid with dato_valid
- alerta_canal  out  N_CANALES  per-channel persistent alarm
- falla_sensor  out  N_CANALES  per-channel timeout fault
- calefactor  out  1  heater request
- ventilador  out  1  fan request
- conflicto  out  1  cold and hot alarms are active at the same time
- estado_actual  out  2  FSM state encoding

## Operation
- FSM states: REPOSO=0, SOLICITA=1, ESPERA=2, EVALUA=3.
- REPOSO:
  - habilitar=1 → SOLICITA.
  - Otherwise stay in REPOSO.
- SOLICITA:
  - sol_valid=1 for exactly one cycle.
  - Always → ESPERA.
  - The wait counter clears.
- ESPERA:
  - dato_valid=1 → latch dato_temp, go to EVALUA.
  - The wait counter reaching TIMEOUT-1 with no dato_valid → timeout, go to EVALUA.
  - dato_valid is ignored in every other state.
- EVALUA, valid sample, in range (TEMP_MIN ≤ t ≤ TEMP_MAX, signed, both limits inclusive):
  - The channel counter clears.
  - alerta_canal[c] clears.
  - falla_sensor[c] clears.
- EVALUA, valid sample, out of range:
  - The channel counter increments and saturates at PERSIST.
  - The direction bit is stored: 1=hot, 0=cold.
  - alerta_canal[c] sets when the counter reaches PERSIST.
  - falla_sensor[c] clears.
  - A cold↔hot swing without an in-range sample between does not reset the counter; the direction bit follows the latest sample.
- EVALUA, timeout:
  - falla_sensor[c] sets.
  - The counter, alarm and direction bit are unchanged.
- Leaving EVALUA:
  - sol_canal advances, wrapping from N_CANALES-1 to 0.
  - habilitar=1 → SOLICITA; habilitar=0 → REPOSO.
  - Dropping habilitar mid-scan lets the current channel finish; the scan resumes at the next channel.
- Actuator outputs:
  - frio = OR over channels of (alerta & ~dir); caliente = OR over channels of (alerta & dir).
  - calefactor = frio & ~caliente.
  - ventilador = caliente & ~frio.
  - conflicto = frio & caliente, and in that case both actuators are 0.

## Timing
- Every output is registered.
- Reset values: state REPOSO, sol_canal 0, every counter 0, every other output 0.
- rst in any state aborts the scan on the next edge; a dato_valid in the same cycle as rst is discarded.
- Latency per channel = 1 (SOLICITA) + k (ESPERA, with k ≥ 1 and k ≤ TIMEOUT) + 1 (EVALUA).
  - dato_valid in the first ESPERA cycle gives 3 cycles per channel.
- alerta_canal, falla_sensor, calefactor, ventilador and conflicto update on the edge that leaves EVALUA.
- The counter width is $clog2(PERSIST+1).
- The wait counter width is $clog2(TIMEOUT).

## Configuration
- PLANIF_TIMEOUT_EN defined:
  - The ESPERA watchdog is present and behaves as described above.
- PLANIF_TIMEOUT_EN undefined:
  - ESPERA waits indefinitely for dato_valid.
  - falla_sensor is tied to 0.
  - The TIMEOUT parameter is unused.

## Structure
- Package monitoreo_pkg holds:
  - TEMP_W=11
  - the state enum estado_planif_t
  - default TEMP_MIN and TEMP_MAX constants
- Sub-module contador_canal, one instance per channel, generated with a generate loop. It contains:
  - the saturating persistence counter
  - the direction bit
  - the alarm bit
  - the fault bit
- The top level holds the FSM, the wait counter, the channel pointer and the actuator logic.

## Test plan
- Reset → all outputs 0 and estado_actual=0. Assert habilitar → sol_valid pulses with sol_canal=0, 1, 2, 3, 0 in order.
- Channel 1 answers 50 on 5 consecutive scans → alerta_canal=4'b0010 and ventilador=1 after the 5th EVALUA. An answer of 25 on the next scan clears both.
- Channel 0 answers 5 five times and channel 2 answers 45 five times → conflicto=1, calefactor=0, ventilador=0.
- Boundaries: an answer of 10 or 40 never increments the counter; 9 and 41 do.
- No reply on channel 3:
  - With the macro defined, falla_sensor[3]=1 after 15 ESPERA cycles, then the scan moves to channel 0.
  - Without the macro, the FSM stays in ESPERA.
- Assert rst during ESPERA with dato_valid=1 → next cycle REPOSO, the sample is discarded, all counters are 0.
